// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_pkg
//  Description : Shared constants for the irrigation sensor front end:
//                channel indices, channel count, default timing and a
//                small helper for deriving counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    // Bit positions of each field input inside raw_in / clean_out
    typedef enum int unsigned {
        CH_L   = 0,
        CH_M   = 1,
        CH_H   = 2,
        CH_T   = 3,
        CH_US  = 4,
        CH_UA  = 5,
        CH_KEY = 6
    } ch_e;

    localparam int unsigned NUM_CH = 7;

    // 1 ms debounce and 10 ms fault qualification at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_FAULT_CYCLES    = 500000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One field input: two-flop synchroniser followed by a
//                stability counter. The output only follows the synchronised
//                input after DEBOUNCE_CYCLES consecutive differing samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the current clean level;
    // any agreeing sample restarts the count.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Synchroniser, counter and clean level registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_conditioner
//  Description : Irrigation controller front end. Debounces the seven field
//                inputs, reports readiness after the startup settle period,
//                toggles the agrodefensive enable on each key press and
//                raises a sticky fault on a persistent impossible tank-level
//                probe combination.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned FAULT_CYCLES    = DEF_FAULT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] clean_out,
    output logic              ad_enable,
    output logic              level_fault,
    output logic              ready
);

    localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, FAULT_CYCLES)) + 1;
    // Startup counter is sized separately so it can always hold 2+DEBOUNCE_CYCLES
    localparam int unsigned ST_W  = $clog2(DEBOUNCE_CYCLES + 2) + 1;

    localparam logic [ST_W-1:0]  READY_AT   = ST_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [ST_W-1:0]  ST_ONE     = ST_W'(1);
    localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_SAT  = CNT_W'(FAULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [ST_W-1:0]  startup_q;
    logic [ST_W-1:0]  startup_d;
    logic             key_prev_q;
    logic             key_prev_d;
    logic             ad_enable_q;
    logic             ad_enable_d;
    logic [CNT_W-1:0] fault_cnt_q;
    logic [CNT_W-1:0] fault_cnt_d;
    logic             level_fault_q;
    logic             level_fault_d;
    logic             key_rise;
    logic             implausible;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (raw_in[g]),
            .clean_o (clean_out[g])
        );
    end

    assign ready       = (startup_q == READY_AT);
    assign key_rise    = clean_out[CH_KEY] & ~key_prev_q;
    // A wetter probe cannot be covered while a drier one below it is dry
    assign implausible = (clean_out[CH_M] & ~clean_out[CH_L]) |
                         (clean_out[CH_H] & ~clean_out[CH_M]);

    // Next state for startup settle, key toggle and fault qualification
    always_comb begin
        startup_d     = (startup_q == READY_AT) ? startup_q : startup_q + ST_ONE;
        key_prev_d    = clean_out[CH_KEY];
        ad_enable_d   = ad_enable_q ^ (ready & key_rise);
        fault_cnt_d   = '0;
        level_fault_d = level_fault_q;
        if (implausible) begin
            fault_cnt_d = (fault_cnt_q == FAULT_SAT) ? fault_cnt_q : fault_cnt_q + CNT_ONE;
            if (fault_cnt_q == FAULT_LAST) begin
                level_fault_d = 1'b1;
            end
        end
    end

    // Top-level state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            startup_q     <= '0;
            key_prev_q    <= 1'b0;
            ad_enable_q   <= 1'b0;
            fault_cnt_q   <= '0;
            level_fault_q <= 1'b0;
        end else begin
            startup_q     <= startup_d;
            key_prev_q    <= key_prev_d;
            ad_enable_q   <= ad_enable_d;
            fault_cnt_q   <= fault_cnt_d;
            level_fault_q <= level_fault_d;
        end
    end

    assign ad_enable   = ad_enable_q;
    assign level_fault = level_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_conditioner
//  Description : Directed bench for sensor_conditioner (DEBOUNCE_CYCLES=4,
//                FAULT_CYCLES=8). Stimulus queues every expected output
//                change with the cycle it must appear on; a monitor pops and
//                compares whenever the sampled outputs change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;

    typedef struct {
        int         cyc;
        logic [9:0] val;   // {ready, level_fault, ad_enable, clean_out[6:0]}
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] raw_in = 7'b0;
    logic [6:0] clean_out;
    logic       ad_enable;
    logic       level_fault;
    logic       ready;

    int         cyc      = 0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    logic [9:0] prev_v   = '0;
    logic [9:0] exp_v    = '0;
    ev_t        sb[$];

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .FAULT_CYCLES    (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raw_in      (raw_in),
        .clean_out   (clean_out),
        .ad_enable   (ad_enable),
        .level_fault (level_fault),
        .ready       (ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected output word v must appear right after clock edge number c
    task automatic push_ev(input int c, input logic [9:0] v);
        sb.push_back('{cyc: c, val: v});
        exp_v = v;
    endtask

    // Monitor: every observed output change must match the next queued event
    always @(negedge clock) begin
        logic [9:0] cur;
        ev_t        e;
        cur = {ready, level_fault, ad_enable, clean_out};
        if (mon_en && (cur !== prev_v)) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL output_change: got %b at cycle %0d, required no change", cur, cyc);
            end else begin
                e = sb.pop_front();
                if ((e.cyc != cyc) || (e.val !== cur)) begin
                    n_fail++;
                    $display("FAIL output_change: got %b at cycle %0d, required %b at cycle %0d",
                             cur, cyc, e.val, e.cyc);
                end
            end
        end
        prev_v = cur;
    end

    initial begin
        // Reset state
        step(3);
        n_tests++;
        if ({ready, level_fault, ad_enable, clean_out} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required %b",
                     {ready, level_fault, ad_enable, clean_out}, 10'h000);
        end
        mon_en = 1'b1;

        // 1: release with all level probes wet; clean and ready after edge 6
        reset  = 1'b0;
        raw_in = 7'b0000111;
        push_ev(cyc + 6, 10'h207);
        step(8);

        // 2: 3-cycle T pulse is filtered, 5-cycle pulse passes with 6-cycle latency
        raw_in[3] = 1'b1;
        step(3);
        raw_in[3] = 1'b0;
        step(10);
        raw_in[3] = 1'b1;
        push_ev(cyc + 6, exp_v | 10'h008);
        step(5);
        raw_in[3] = 1'b0;
        push_ev(cyc + 6, exp_v & ~10'h008);
        step(12);

        // 3: key high/low/high: toggle on each rising edge only
        raw_in[6] = 1'b1;
        push_ev(cyc + 6, exp_v | 10'h040);
        push_ev(cyc + 7, exp_v | 10'h080);
        step(20);
        raw_in[6] = 1'b0;
        push_ev(cyc + 6, exp_v & ~10'h040);
        step(20);
        raw_in[6] = 1'b1;
        push_ev(cyc + 6, exp_v | 10'h040);
        push_ev(cyc + 7, exp_v & ~10'h080);
        step(20);
        raw_in[6] = 1'b0;
        push_ev(cyc + 6, exp_v & ~10'h040);
        step(10);

        // 4: M without L sets the fault 8 cycles after clean M; sticky until reset
        raw_in[2:0] = 3'b000;
        push_ev(cyc + 6, exp_v & ~10'h007);
        step(10);
        raw_in[1] = 1'b1;
        push_ev(cyc + 6, exp_v | 10'h002);
        push_ev(cyc + 14, exp_v | 10'h100);
        step(20);
        raw_in[0] = 1'b1;
        push_ev(cyc + 6, exp_v | 10'h001);
        step(10);
        reset = 1'b1;
        push_ev(cyc + 1, 10'h000);
        step(1);
        reset = 1'b0;
        push_ev(cyc + 6, 10'h203);
        step(10);

        // 5: implausible pattern for only 7 cycles, twice; fault must stay clear
        for (int i = 0; i < 2; i++) begin
            raw_in[0] = 1'b0;
            push_ev(cyc + 6, exp_v & ~10'h001);
            step(7);
            raw_in[0] = 1'b1;
            push_ev(cyc + 6, exp_v | 10'h001);
            step(12);
        end

        // 6: reset while the Us counter sits at 3 discards all progress
        raw_in[4] = 1'b1;
        step(5);
        reset = 1'b1;
        push_ev(cyc + 1, 10'h000);
        step(1);
        reset = 1'b0;
        push_ev(cyc + 6, 10'h213);
        step(10);

        // Every queued event must have been observed
        step(3);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
